// File: rtl/jericalla_pkg.sv
// Shared definitions for the fetch/sequencer stage.
// Contents: opcode encodings, sequencer state encodings and instruction
// word field offset helpers. Word layout, MSB-first: opcode(3), rd, rs1, rs2.
package jericalla_pkg;

  // Opcodes as seen by the control unit
  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_SLT  = 3'b010;
  localparam logic [2:0] OP_SW   = 3'b011;
  localparam logic [2:0] OP_LW   = 3'b100;
  localparam logic [2:0] OP_HALT = 3'b111;

  // Sequencer states
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_FETCH  = 3'd1;
  localparam logic [2:0] ST_LATCH  = 3'd2;
  localparam logic [2:0] ST_DECIDE = 3'd3;
  localparam logic [2:0] ST_EXEC   = 3'd4;
  localparam logic [2:0] ST_HALT   = 3'd5;

  // Bit offsets of the fields inside a word of width 3 + 3*ra_w
  function automatic int unsigned op_lsb(input int unsigned ra_w);
    return 3 * ra_w;
  endfunction

  function automatic int unsigned rd_lsb(input int unsigned ra_w);
    return 2 * ra_w;
  endfunction

  function automatic int unsigned rs1_lsb(input int unsigned ra_w);
    return ra_w;
  endfunction

  function automatic int unsigned rs2_lsb(input int unsigned ra_w);
    return 0;
  endfunction

endpackage

// File: rtl/pc_reg.sv
// Program counter register.
// Ports:
//   clk          - clock, rising edge
//   rst_n        - asynchronous active-low reset (pc = 0)
//   i_load_zero  - load 0 (takes priority over increment)
//   i_inc        - increment, wrapping at 2**PC_W
//   o_pc         - current program counter
module pc_reg #(
  parameter int unsigned PC_W = 6
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_load_zero,
  input  logic            i_inc,
  output logic [PC_W-1:0] o_pc
);

  logic [PC_W-1:0] r_pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc <= '0;
    end else if (i_load_zero) begin
      r_pc <= '0;
    end else if (i_inc) begin
      r_pc <= r_pc + {{(PC_W-1){1'b0}}, 1'b1};
    end
  end

  assign o_pc = r_pc;

endmodule

// File: rtl/fetch_seq.sv
// Instruction fetch / sequencer stage feeding the control unit.
// Owns the PC, reads a synchronous instruction ROM, latches the word into the
// IR and issues one instruction at a time with a registered inst_valid.
// Ports:
//   clk, rst_n           - clock and asynchronous active-low reset
//   start                - pulse, begins execution at PC 0 from IDLE/HALT
//   stall                - freezes EXEC while high
//   imem_addr/imem_data  - ROM address out, ROM data in (one cycle later)
//   inst, rd/rs1/rs2_addr- opcode (MSB-first) and register fields from the IR
//   inst_valid           - fields are to be executed this cycle
//   pc                   - address of the instruction held in the IR
//   halted, illegal      - stopped on HALT; sticky illegal-opcode flag
// Build option: ILLEGAL_TRAP_EN makes an illegal opcode halt with pc left on
// the offending word instead of skipping it.
module fetch_seq
  import jericalla_pkg::*;
#(
  parameter int unsigned PC_W     = 6,
  parameter int unsigned RA_W     = 5,
  parameter int unsigned MEM_HOLD = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              stall,
  output logic [PC_W-1:0]   imem_addr,
  input  logic [3*RA_W+2:0] imem_data,
  output logic [0:2]        inst,
  output logic [RA_W-1:0]   rd_addr,
  output logic [RA_W-1:0]   rs1_addr,
  output logic [RA_W-1:0]   rs2_addr,
  output logic              inst_valid,
  output logic [PC_W-1:0]   pc,
  output logic              halted,
  output logic              illegal
);

  localparam int unsigned OP_LSB  = op_lsb(RA_W);
  localparam int unsigned RD_LSB  = rd_lsb(RA_W);
  localparam int unsigned RS1_LSB = rs1_lsb(RA_W);
  localparam int unsigned RS2_LSB = rs2_lsb(RA_W);
  localparam int unsigned CNT_W   = (MEM_HOLD > 1) ? $clog2(MEM_HOLD + 1) : 1;

  localparam logic [CNT_W-1:0] HOLD_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] HOLD_MEM = CNT_W'(MEM_HOLD);

  logic [2:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [0:2]       r_op;
  logic [RA_W-1:0]  r_rd;
  logic [RA_W-1:0]  r_rs1;
  logic [RA_W-1:0]  r_rs2;
  logic             r_valid;
  logic             r_illegal;

  logic [2:0]       w_state_d;
  logic [CNT_W-1:0] w_cnt_d;
  logic             w_pc_zero;
  logic             w_pc_inc;
  logic             w_illegal_d;
  logic [PC_W-1:0]  w_pc;

  pc_reg #(
    .PC_W (PC_W)
  ) u_pc_reg (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_load_zero (w_pc_zero),
    .i_inc       (w_pc_inc),
    .o_pc        (w_pc)
  );

  always_comb begin
    w_state_d   = r_state;
    w_cnt_d     = r_cnt;
    w_pc_zero   = 1'b0;
    w_pc_inc    = 1'b0;
    w_illegal_d = r_illegal;
    unique case (r_state)
      ST_IDLE, ST_HALT: begin
        if (start) begin
          w_state_d   = ST_FETCH;
          w_pc_zero   = 1'b1;
          w_illegal_d = 1'b0;
        end
      end
      ST_FETCH:  w_state_d = ST_LATCH;
      ST_LATCH:  w_state_d = ST_DECIDE;
      ST_DECIDE: begin
        unique case (r_op)
          OP_ADD, OP_SUB, OP_SLT: begin
            w_state_d = ST_EXEC;
            w_cnt_d   = HOLD_ONE;
          end
          OP_SW, OP_LW: begin
            w_state_d = ST_EXEC;
            w_cnt_d   = HOLD_MEM;
          end
          OP_HALT: w_state_d = ST_HALT;
          default: begin
            w_illegal_d = 1'b1;
`ifdef ILLEGAL_TRAP_EN
            w_state_d   = ST_HALT;
`else
            w_pc_inc    = 1'b1;
            w_state_d   = ST_FETCH;
`endif
          end
        endcase
      end
      ST_EXEC: begin
        if (!stall) begin
          if (r_cnt == HOLD_ONE) begin
            w_pc_inc  = 1'b1;
            w_state_d = ST_FETCH;
          end else begin
            w_cnt_d = r_cnt - HOLD_ONE;
          end
        end
      end
      default: w_state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_op      <= '0;
      r_rd      <= '0;
      r_rs1     <= '0;
      r_rs2     <= '0;
      r_valid   <= 1'b0;
      r_illegal <= 1'b0;
    end else begin
      r_state   <= w_state_d;
      r_cnt     <= w_cnt_d;
      r_illegal <= w_illegal_d;
      // Moore output: high for every cycle spent in EXEC
      r_valid   <= (w_state_d == ST_EXEC);
      if (r_state == ST_LATCH) begin
        r_op  <= imem_data[OP_LSB +: 3];
        r_rd  <= imem_data[RD_LSB +: RA_W];
        r_rs1 <= imem_data[RS1_LSB +: RA_W];
        r_rs2 <= imem_data[RS2_LSB +: RA_W];
      end
    end
  end

  // The ROM sees the PC directly; it is registered, so data follows one cycle later
  assign imem_addr  = w_pc;
  assign pc         = w_pc;
  assign inst       = r_op;
  assign rd_addr    = r_rd;
  assign rs1_addr   = r_rs1;
  assign rs2_addr   = r_rs2;
  assign inst_valid = r_valid;
  assign halted     = (r_state == ST_HALT);
  assign illegal    = r_illegal;

endmodule

// File: tb/tb_fetch_seq.sv
module tb_fetch_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        stall;
  logic [5:0]  imem_addr;
  logic [17:0] imem_data;
  logic [0:2]  inst;
  logic [4:0]  rd_addr;
  logic [4:0]  rs1_addr;
  logic [4:0]  rs2_addr;
  logic        inst_valid;
  logic [5:0]  pc;
  logic        halted;
  logic        illegal;

  // Second instance with a 2-bit PC to exercise wrap-around
  logic        start2;
  logic [1:0]  imem_addr2;
  logic [17:0] imem_data2;
  logic [0:2]  inst2;
  logic [4:0]  rd2;
  logic [4:0]  rs12;
  logic [4:0]  rs22;
  logic        valid2;
  logic [1:0]  pc2;
  logic        halted2;
  logic        illegal2;

  logic [17:0] rom [0:63];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  always @(posedge clk) imem_data <= rom[imem_addr];
  assign imem_data2 = {3'b000, 5'd1, 5'd2, 5'd3};

  fetch_seq dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .stall      (stall),
    .imem_addr  (imem_addr),
    .imem_data  (imem_data),
    .inst       (inst),
    .rd_addr    (rd_addr),
    .rs1_addr   (rs1_addr),
    .rs2_addr   (rs2_addr),
    .inst_valid (inst_valid),
    .pc         (pc),
    .halted     (halted),
    .illegal    (illegal)
  );

  fetch_seq #(
    .PC_W (2)
  ) dut2 (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start2),
    .stall      (1'b0),
    .imem_addr  (imem_addr2),
    .imem_data  (imem_data2),
    .inst       (inst2),
    .rd_addr    (rd2),
    .rs1_addr   (rs12),
    .rs2_addr   (rs22),
    .inst_valid (valid2),
    .pc         (pc2),
    .halted     (halted2),
    .illegal    (illegal2)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic found;
    logic bad;
    int   nv;

    rst_n  = 1'b0;
    start  = 1'b0;
    start2 = 1'b0;
    stall  = 1'b0;
    for (int i = 0; i < 64; i++) rom[i] = {3'b111, 15'd0};
    rom[0] = {3'b000, 5'd3, 5'd1, 5'd2};
    rom[1] = {3'b011, 5'd4, 5'd5, 5'd6};
    rom[2] = {3'b111, 15'd0};
    rom[3] = {3'b101, 5'd1, 5'd1, 5'd1};
    rom[4] = {3'b010, 5'd7, 5'd8, 5'd9};
    rom[5] = {3'b111, 15'd0};

    step();
    step();
    chk("rst_valid", inst_valid, 0);
    chk("rst_pc", pc, 0);
    chk("rst_addr", imem_addr, 0);
    chk("rst_inst", inst, 0);
    chk("rst_rd", rd_addr, 0);
    chk("rst_rs1", rs1_addr, 0);
    chk("rst_rs2", rs2_addr, 0);
    chk("rst_halted", halted, 0);
    chk("rst_illegal", illegal, 0);

    rst_n = 1'b1;
    step();
    start = 1'b1;
    step();                      // cycle 1: FETCH
    start = 1'b0;
    chk("c1_valid", inst_valid, 0);
    step();
    step();
    step();                      // cycle 4: first issue
    chk("c4_valid", inst_valid, 1);
    chk("c4_inst", inst, 3'b000);
    chk("c4_rd", rd_addr, 3);
    chk("c4_rs1", rs1_addr, 1);
    chk("c4_rs2", rs2_addr, 2);
    chk("c4_pc", pc, 0);
    step();                      // cycle 5: fetching pc 1
    chk("c5_valid", inst_valid, 0);
    chk("c5_addr", imem_addr, 1);
    step();
    step();
    step();                      // cycle 8: SW in EXEC

    nv = 0;
    for (int i = 0; i < 8; i++) begin
      if (inst_valid) begin
        nv++;
        chk("sw_inst", inst, 3'b011);
        chk("sw_rd", rd_addr, 4);
        chk("sw_rs2", rs2_addr, 6);
        chk("sw_pc", pc, 1);
      end
      stall = (i < 3);
      step();
    end
    stall = 1'b0;
    chk("sw_valid_cycles", nv, 5);
    chk("halt_set", halted, 1);

    bad = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (inst_valid) bad = 1'b1;
    end
    chk("halt_no_valid", bad, 0);
    chk("halt_still", halted, 1);

    rom[2] = {3'b000, 5'd10, 5'd11, 5'd12};
    start = 1'b1;
    step();
    start = 1'b0;
    chk("restart_halted", halted, 0);
    chk("restart_addr", imem_addr, 0);

`ifndef ILLEGAL_TRAP_EN
    found = 1'b0;
    bad   = 1'b0;
    for (int k = 0; k < 60; k++) begin
      step();
      if (inst_valid && pc == 6'd3) bad = 1'b1;
      if (inst_valid && pc == 6'd4) begin
        found = 1'b1;
        break;
      end
    end
    chk("ill_reach_pc4", found, 1);
    chk("ill_no_issue_pc3", bad, 0);
    chk("ill_flag", illegal, 1);
    chk("pc4_inst", inst, 3'b010);
    chk("pc4_rd", rd_addr, 7);
    found = 1'b0;
    for (int k = 0; k < 20; k++) begin
      step();
      if (halted) begin
        found = 1'b1;
        break;
      end
    end
    chk("halt5_reached", found, 1);
    chk("halt5_pc", pc, 5);
`else
    found = 1'b0;
    for (int k = 0; k < 60; k++) begin
      step();
      if (halted) begin
        found = 1'b1;
        break;
      end
    end
    chk("trap_halted", found, 1);
    chk("trap_pc", pc, 3);
`endif
    chk("ill_sticky", illegal, 1);

    rom[0] = {3'b011, 5'd1, 5'd2, 5'd3};
    start = 1'b1;
    step();
    start = 1'b0;
    chk("start_clr_illegal", illegal, 0);
    found = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step();
      if (inst_valid) begin
        found = 1'b1;
        break;
      end
    end
    chk("sw2_issue", found, 1);
    chk("sw2_inst", inst, 3'b011);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", inst_valid, 0);
    chk("arst_inst", inst, 0);
    chk("arst_rd", rd_addr, 0);
    chk("arst_pc", pc, 0);
    chk("arst_halted", halted, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    step();
    step();
    chk("idle_valid", inst_valid, 0);
    chk("idle_addr", imem_addr, 0);

    start2 = 1'b1;
    step();
    start2 = 1'b0;
    nv = 0;
    for (int k = 0; k < 40; k++) begin
      step();
      if (valid2) begin
        chk("wrap_pc", 32'(pc2), 32'(nv % 4));
        nv++;
        if (nv == 5) break;
      end
    end
    chk("wrap_issues", nv, 5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
